// File: rtl/sd_spi_responder.sv
// SD card responder for SPI mode 0: decodes command frames and answers R1/R3/R7.
// Serves CMD17 single-block reads from an external byte memory with token and CRC16.
module sd_spi_responder #(
  parameter int unsigned INIT_RETRIES = 2,
  parameter int unsigned NAC_BYTES    = 2,
  parameter logic [31:0] OCR          = 32'hC0FF8000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sck,
  input  logic        mosi,
  input  logic        cs,
  output logic        miso,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data,
  output logic        cmd_valid,
  output logic [5:0]  last_cmd,
  output logic        idle_state
);

  typedef enum logic [2:0] {
    IDLE, CMD, NCR, RESP, RD_WAIT, RD_TOKEN, RD_DATA, RD_CRC
  } state_t;

  localparam logic [7:0] RETRY_INIT = 8'(INIT_RETRIES);
  localparam logic [7:0] NAC_INIT   = 8'(NAC_BYTES);

  state_t      state;
  logic [1:0]  sck_sync;
  logic [1:0]  mosi_sync;
  logic [1:0]  cs_sync;
  logic        sck_d;
  logic        cs_d;
  logic [2:0]  bit_cnt;
  logic [6:0]  rx_sh;
  logic [7:0]  tx_sh;
  logic [7:0]  rx_byte;
  logic        rise;
  logic        fall;
  logic        cs_rise;
  logic        byte_done;
  logic [5:0]  cmd_idx;
  logic [22:0] arg;
  logic [2:0]  cnt;
  logic        app;
  logic [7:0]  retry;
  logic [7:0]  nac;
  logic [39:0] resp_buf;
  logic [2:0]  resp_cnt;
  logic        rd_pend;
  logic [8:0]  byte_idx;
  logic [15:0] crc;

  logic [7:0]  dec_r1;
  logic [31:0] dec_tail;
  logic [2:0]  dec_len;
  logic        dec_rd;
  logic        dec_idle;
  logic [7:0]  dec_retry;

  function automatic logic [15:0] crc16_byte(
    input logic [15:0] c,
    input logic [7:0]  d
  );
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction

  assign rise      = sck_sync[1] & ~sck_d;
  assign fall      = ~sck_sync[1] & sck_d;
  assign cs_rise   = cs_sync[1] & ~cs_d;
  assign byte_done = rise & ~cs_sync[1] & (bit_cnt == 3'd7);
  assign rx_byte   = {rx_sh, mosi_sync[1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync  <= 2'b00;
      mosi_sync <= 2'b11;
      cs_sync   <= 2'b11;
      sck_d     <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[0], sck};
      mosi_sync <= {mosi_sync[0], mosi};
      cs_sync   <= {cs_sync[0], cs};
      sck_d     <= sck_sync[1];
      cs_d      <= cs_sync[1];
    end
  end

  // Response and card-state update for the command just framed
  always_comb begin
    dec_r1    = {7'b0, idle_state} | 8'h04;
    dec_tail  = 32'h0;
    dec_len   = 3'd1;
    dec_rd    = 1'b0;
    dec_idle  = idle_state;
    dec_retry = retry;
    unique case (1'b1)
      cmd_idx == 6'd0: begin
        dec_r1    = 8'h01;
        dec_idle  = 1'b1;
        dec_retry = RETRY_INIT;
      end
      cmd_idx == 6'd8: begin
        dec_r1   = {7'b0, idle_state};
        dec_tail = {20'h0, arg[11:0]};
        dec_len  = 3'd5;
      end
      cmd_idx == 6'd16,
      cmd_idx == 6'd55: dec_r1 = {7'b0, idle_state};
      cmd_idx == 6'd41 && app: begin
        if (retry != 8'd0) begin
          dec_r1    = 8'h01;
          dec_retry = retry - 8'd1;
        end else begin
          dec_r1   = 8'h00;
          dec_idle = 1'b0;
        end
      end
      cmd_idx == 6'd58: begin
        dec_r1   = {7'b0, idle_state};
        dec_tail = OCR;
        dec_len  = 3'd5;
      end
      cmd_idx == 6'd17: begin
        dec_r1 = idle_state ? 8'h05 : 8'h00;
        dec_rd = ~idle_state;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      rx_sh      <= 7'h0;
      tx_sh      <= 8'hFF;
      miso       <= 1'b1;
      mem_rd     <= 1'b0;
      mem_addr   <= 32'h0;
      cmd_valid  <= 1'b0;
      last_cmd   <= 6'd0;
      idle_state <= 1'b1;
      app        <= 1'b0;
      retry      <= RETRY_INIT;
      nac        <= 8'd0;
      cmd_idx    <= 6'd0;
      arg        <= 23'h0;
      cnt        <= 3'd0;
      resp_buf   <= 40'h0;
      resp_cnt   <= 3'd0;
      rd_pend    <= 1'b0;
      byte_idx   <= 9'd0;
      crc        <= 16'h0;
    end else begin
      cmd_valid <= 1'b0;
      mem_rd    <= 1'b0;
      if (mem_rd) begin
        tx_sh <= mem_data;
        crc   <= crc16_byte(crc, mem_data);
      end
      if (cs_rise) begin
        state   <= IDLE;
        bit_cnt <= 3'd0;
        miso    <= 1'b1;
      end else if (cs_sync[1]) begin
        bit_cnt <= 3'd0;
        miso    <= 1'b1;
      end else begin
        if (rise) begin
          rx_sh   <= rx_byte[6:0];
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (state == IDLE || state == CMD) begin
          miso <= 1'b1;
        end else if (fall) begin
          miso  <= tx_sh[7];
          tx_sh <= {tx_sh[6:0], 1'b1};
        end
        if (byte_done) begin
          unique case (state)
            IDLE: begin
              if (rx_byte[7:6] == 2'b01) begin
                cmd_idx <= rx_byte[5:0];
                cnt     <= 3'd0;
                state   <= CMD;
              end
            end
            CMD: begin
              if (cnt != 3'd4) begin
                arg <= {arg[14:0], rx_byte};
                cnt <= cnt + 3'd1;
              end else if (!rx_byte[0]) begin
                state <= IDLE;
              end else begin
                cmd_valid  <= 1'b1;
                last_cmd   <= cmd_idx;
                idle_state <= dec_idle;
                retry      <= dec_retry;
                app        <= (cmd_idx == 6'd55);
                resp_buf   <= {dec_r1, dec_tail};
                resp_cnt   <= dec_len;
                rd_pend    <= dec_rd;
                tx_sh      <= 8'hFF;
                state      <= NCR;
              end
            end
            NCR, RESP: begin
              if (resp_cnt != 3'd0) begin
                tx_sh    <= resp_buf[39:32];
                resp_buf <= {resp_buf[31:0], 8'h00};
                resp_cnt <= resp_cnt - 3'd1;
                state    <= RESP;
              end else if (rd_pend) begin
                crc <= 16'h0;
                if (NAC_BYTES == 0) begin
                  tx_sh <= 8'hFE;
                  state <= RD_TOKEN;
                end else begin
                  tx_sh <= 8'hFF;
                  nac   <= NAC_INIT - 8'd1;
                  state <= RD_WAIT;
                end
              end else begin
                state <= IDLE;
              end
            end
            RD_WAIT: begin
              if (nac == 8'd0) begin
                tx_sh <= 8'hFE;
                state <= RD_TOKEN;
              end else begin
                tx_sh <= 8'hFF;
                nac   <= nac - 8'd1;
              end
            end
            RD_TOKEN: begin
              byte_idx <= 9'd0;
              mem_rd   <= 1'b1;
              mem_addr <= {arg, 9'd0};
              state    <= RD_DATA;
            end
            RD_DATA: begin
              if (byte_idx == 9'd511) begin
                tx_sh <= crc[15:8];
                cnt   <= 3'd0;
                state <= RD_CRC;
              end else begin
                byte_idx <= byte_idx + 9'd1;
                mem_rd   <= 1'b1;
                mem_addr <= {arg, byte_idx + 9'd1};
              end
            end
            RD_CRC: begin
              if (cnt == 3'd0) begin
                tx_sh <= crc[7:0];
                cnt   <= 3'd1;
              end else begin
                state <= IDLE;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_sd_spi_responder.sv
// Directed bench for sd_spi_responder: command responses, block reads, abort and reset.
module tb_sd_spi_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sck = 1'b0;
  logic        mosi = 1'b1;
  logic        cs = 1'b1;
  logic        miso;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic        cmd_valid;
  logic [5:0]  last_cmd;
  logic        idle_state;

  logic [7:0]  mem_val = 8'hFF;
  int          vectors = 0;
  int          errors = 0;
  int          cv_cnt = 0;
  int          rd_cnt = 0;
  int          addr_err = 0;
  logic [31:0] rd_base = 32'h0;
  logic [31:0] last_addr = 32'h0;

  assign mem_data = mem_val;

  always #5 clk = ~clk;

  sd_spi_responder dut (
    .clk        (clk),
    .rst        (rst),
    .sck        (sck),
    .mosi       (mosi),
    .cs         (cs),
    .miso       (miso),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .cmd_valid  (cmd_valid),
    .last_cmd   (last_cmd),
    .idle_state (idle_state)
  );

  always @(negedge clk) begin
    if (cmd_valid === 1'b1) cv_cnt++;
    if (mem_rd === 1'b1) begin
      if (mem_addr !== rd_base + 32'(rd_cnt)) addr_err++;
      last_addr = mem_addr;
      rd_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] t, output logic [7:0] r);
    for (int i = 7; i >= 0; i--) begin
      mosi = t[i];
      #40 sck = 1'b1;
      r[i] = miso;
      #40 sck = 1'b0;
    end
  endtask

  task automatic send(input logic [47:0] f);
    logic [7:0] d;
    for (int k = 0; k < 6; k++) xfer(f[47-8*k -: 8], d);
  endtask

  task automatic rsp(input string tag, input logic [7:0] exp);
    logic [7:0] b;
    xfer(8'hFF, b);
    chk(tag, {24'h0, b}, {24'h0, exp});
  endtask

  task automatic sel();
    cs = 1'b0;
    #80;
  endtask

  task automatic desel();
    #80 cs = 1'b1;
    #160;
  endtask

  task automatic rd_head(input string tag);
    rsp({tag, "_ncr"}, 8'hFF);
    rsp({tag, "_r1"}, 8'h00);
    rsp({tag, "_nac0"}, 8'hFF);
    rsp({tag, "_nac1"}, 8'hFF);
    rsp({tag, "_token"}, 8'hFE);
  endtask

  task automatic rd_block(input string tag, input logic [7:0] d,
                          input logic [15:0] c);
    logic [7:0] b;
    int bad;
    rd_head(tag);
    bad = 0;
    for (int n = 0; n < 512; n++) begin
      xfer(8'hFF, b);
      if (b !== d) bad++;
    end
    chk({tag, "_data"}, 32'(bad), 32'h0);
    rsp({tag, "_crc_hi"}, c[15:8]);
    rsp({tag, "_crc_lo"}, c[7:0]);
  endtask

  initial begin
    logic [7:0] b;
    #2;
    #50;
    chk("rst_miso", {31'h0, miso}, 32'h1);
    chk("rst_idle", {31'h0, idle_state}, 32'h1);
    chk("rst_mem_rd", {31'h0, mem_rd}, 32'h0);
    chk("rst_cmd_valid", {31'h0, cmd_valid}, 32'h0);
    rst = 1'b0;
    #50;
    chk("post_rst_miso", {31'h0, miso}, 32'h1);
    chk("post_rst_addr", mem_addr, 32'h0);
    chk("post_rst_last", {26'h0, last_cmd}, 32'h0);

    sel();
    send(48'h40_0000_0000_95);
    rsp("cmd0_ncr", 8'hFF);
    rsp("cmd0_r1", 8'h01);
    desel();
    chk("cmd0_valid_cnt", 32'(cv_cnt), 32'd1);
    chk("cmd0_last", {26'h0, last_cmd}, 32'd0);

    sel();
    send(48'h48_0000_01AA_87);
    rsp("cmd8_ncr", 8'hFF);
    rsp("cmd8_r1", 8'h01);
    rsp("cmd8_b1", 8'h00);
    rsp("cmd8_b2", 8'h00);
    rsp("cmd8_b3", 8'h01);
    rsp("cmd8_b4", 8'hAA);
    desel();
    chk("cmd8_last", {26'h0, last_cmd}, 32'd8);

    sel();
    send(48'h77_0000_0000_65);
    rsp("cmd55a_ncr", 8'hFF);
    rsp("cmd55a_r1", 8'h01);
    send(48'h69_4000_0000_77);
    rsp("acmd41a_ncr", 8'hFF);
    rsp("acmd41a_r1", 8'h01);
    send(48'h77_0000_0000_65);
    rsp("cmd55b_ncr", 8'hFF);
    rsp("cmd55b_r1", 8'h01);
    send(48'h69_4000_0000_77);
    rsp("acmd41b_ncr", 8'hFF);
    rsp("acmd41b_r1", 8'h01);
    send(48'h77_0000_0000_65);
    rsp("cmd55c_r1_ncr", 8'hFF);
    rsp("cmd55c_r1", 8'h01);
    send(48'h69_4000_0000_77);
    rsp("acmd41c_ncr", 8'hFF);
    rsp("acmd41c_r1", 8'h00);
    desel();
    chk("acmd41_idle", {31'h0, idle_state}, 32'h0);
    chk("acmd41_last", {26'h0, last_cmd}, 32'd41);

    sel();
    send(48'h7A_0000_0000_FD);
    rsp("cmd58_ncr", 8'hFF);
    rsp("cmd58_r1", 8'h00);
    rsp("cmd58_ocr3", 8'hC0);
    rsp("cmd58_ocr2", 8'hFF);
    rsp("cmd58_ocr1", 8'h80);
    rsp("cmd58_ocr0", 8'h00);
    send(48'h45_0000_0000_01);
    rsp("cmd5_ncr", 8'hFF);
    rsp("cmd5_r1", 8'h04);
    desel();
    chk("cmd5_last", {26'h0, last_cmd}, 32'd5);
    chk("valid_cnt_10", 32'(cv_cnt), 32'd10);

    sel();
    send(48'h50_0000_0200_14);
    rsp("badend_b0", 8'hFF);
    rsp("badend_b1", 8'hFF);
    rsp("badend_b2", 8'hFF);
    desel();
    chk("badend_valid_cnt", 32'(cv_cnt), 32'd10);
    chk("badend_last", {26'h0, last_cmd}, 32'd5);

    mem_val = 8'hFF;
    rd_cnt = 0;
    addr_err = 0;
    rd_base = 32'h600;
    sel();
    send(48'h51_0000_0003_01);
    rd_block("rd_ff", 8'hFF, 16'h7FA1);
    desel();
    chk("rd_ff_count", 32'(rd_cnt), 32'd512);
    chk("rd_ff_addr_err", 32'(addr_err), 32'd0);
    chk("rd_ff_last_addr", last_addr, 32'h7FF);

    rd_cnt = 0;
    addr_err = 0;
    rd_base = 32'hA00;
    sel();
    send(48'h51_0000_0005_01);
    rd_head("abort");
    for (int n = 0; n < 100; n++) xfer(8'hFF, b);
    cs = 1'b1;
    #100;
    chk("abort_miso", {31'h0, miso}, 32'h1);
    chk("abort_count", 32'(rd_cnt), 32'd101);
    #600;
    chk("abort_count_hold", 32'(rd_cnt), 32'd101);
    chk("abort_mem_rd", {31'h0, mem_rd}, 32'h0);
    chk("abort_addr_err", 32'(addr_err), 32'd0);

    mem_val = 8'h00;
    rd_cnt = 0;
    addr_err = 0;
    rd_base = 32'h200;
    sel();
    send(48'h51_0000_0001_01);
    rd_block("rd_zero", 8'h00, 16'h0000);
    desel();
    chk("rd_zero_count", 32'(rd_cnt), 32'd512);
    chk("rd_zero_addr_err", 32'(addr_err), 32'd0);
    chk("rd_zero_last_addr", last_addr, 32'h3FF);

    mem_val = 8'h5A;
    rd_cnt = 0;
    addr_err = 0;
    rd_base = 32'h600;
    sel();
    send(48'h51_0000_0003_01);
    rd_head("rstrd");
    for (int n = 0; n < 4; n++) xfer(8'hFF, b);
    rst = 1'b1;
    #10;
    chk("rstrd_miso", {31'h0, miso}, 32'h1);
    chk("rstrd_mem_rd", {31'h0, mem_rd}, 32'h0);
    chk("rstrd_idle", {31'h0, idle_state}, 32'h1);
    chk("rstrd_addr", mem_addr, 32'h0);
    cs = 1'b1;
    #40;
    rst = 1'b0;
    #200;
    chk("rstrd_count", 32'(rd_cnt), 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
